alu_arbiter: RTL and testbench

Shares one combinational ALU (3-bit func, 32-bit operands, 32-bit out, integer-overflow flag) among NREQ requesters, e.g. the EX-stage integer path and the address/branch-compare path. Accepts one operation at a time over a valid/ready request channel, drives the shared ALU from registered operands, captures the result, and returns it over a per-requester valid/ready response channel. Sits in the EX stage between the requesters and the ALU instance.

---
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Arbitrates one shared combinational ALU among NREQ requesters: accept, execute, respond.
// Define ALU_ARB_RR_EN for round-robin arbitration; the default build uses fixed lowest-index priority.
module alu_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_func,
    input  logic [32*NREQ-1:0]   req_srca,
    input  logic [32*NREQ-1:0]   req_srcb,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_data,
    output logic                 rsp_ovf,
    output logic [2:0]           alu_func,
    output logic [31:0]          alu_srca,
    output logic [31:0]          alu_srcb,
    input  logic [31:0]          alu_out,
    input  logic                 alu_intovf
);

    localparam int DATA_W = 32;
    localparam int OW     = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [2:0]          func_q, func_d;
    logic [DATA_W-1:0]   srca_q, srca_d;
    logic [DATA_W-1:0]   srcb_q, srcb_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                ovf_q, ovf_d;
    logic [OW-1:0]       gnt;
    logic                found;

`ifdef ALU_ARB_RR_EN
    logic [OW-1:0]       ptr_q, ptr_d;
    int                  idx;

    // Search begins one past the last granted requester and wraps.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = OW'(idx);
            end
        end
    end
`else
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found = 1'b1;
                gnt   = OW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        func_d    = func_q;
        srca_d    = srca_q;
        srcb_d    = srcb_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
`ifdef ALU_ARB_RR_EN
        ptr_d     = ptr_q;
`endif
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[gnt] = 1'b1;
                    owner_d        = gnt;
                    func_d         = req_func[3*int'(gnt) +: 3];
                    srca_d         = req_srca[DATA_W*int'(gnt) +: DATA_W];
                    srcb_d         = req_srcb[DATA_W*int'(gnt) +: DATA_W];
`ifdef ALU_ARB_RR_EN
                    ptr_d          = gnt;
`endif
                    state_d        = EXEC;
                end
            end
            EXEC: begin
                // Overflow only has meaning for add (000) and sub (001).
                res_d   = alu_out;
                ovf_d   = alu_intovf && (func_q[2:1] == 2'b00);
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= '0;
            func_q  <= '0;
            srca_q  <= '0;
            srcb_q  <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
            ptr_q   <= OW'(NREQ - 1);
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            func_q  <= func_d;
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
`ifdef ALU_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign alu_func = func_q;
    assign alu_srca = srca_q;
    assign alu_srcb = srcb_q;
    assign rsp_data = res_q;
    assign rsp_ovf  = ovf_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter (NREQ=2): models the external ALU and checks grants, latency, results and overflow.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [5:0]  req_func;
    logic [63:0] req_srca, req_srcb;
    logic [31:0] rsp_data, alu_srca, alu_srcb, alu_out;
    logic        rsp_ovf, alu_intovf;
    logic [2:0]  alu_func;

    int nvec = 0;
    int nmis = 0;
    int last_gnt = 1;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(2)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_func(req_func), .req_srca(req_srca), .req_srcb(req_srcb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
        .alu_func(alu_func), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
        .alu_out(alu_out), .alu_intovf(alu_intovf)
    );

    // The shared ALU: result, and a raw overflow flag that is not masked by function.
    function automatic logic [31:0] alu_calc(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return {31'b0, $signed(a) < $signed(b)};
            3'd3:    return {31'b0, a < b};
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return a ^ b;
            default: return a << b[4:0];
        endcase
    endfunction

    function automatic logic alu_raw_ovf(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = (f == 3'd1) ? a - b : a + b;
        if (f == 3'd1) return (a[31] != b[31]) && (s[31] != a[31]);
        return (a[31] == b[31]) && (s[31] != a[31]);
    endfunction

    assign alu_out    = alu_calc(alu_func, alu_srca, alu_srcb);
    assign alu_intovf = alu_raw_ovf(alu_func, alu_srca, alu_srcb);

    // Expected overflow: true signed result out of 32-bit range, for add/sub only.
    function automatic logic exp_ovf(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (f == 3'd0)      r = sa + sb;
        else if (f == 3'd1) r = sa - sb;
        else                return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic int pick(input logic [1:0] m);
`ifdef ALU_ARB_RR_EN
        for (int k = 1; k <= 2; k++) begin
            if (m[(last_gnt + k) % 2]) return (last_gnt + k) % 2;
        end
`else
        for (int i = 0; i < 2; i++) begin
            if (m[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        req_func[3*r +: 3]  = f;
        req_srca[32*r +: 32] = a;
        req_srcb[32*r +: 32] = b;
    endtask

    // Called just after a rising edge with the DUT in IDLE; returns just after the edge that retires the response.
    task automatic do_op(input logic [1:0] vm, input int g, input logic [31:0] ed, input logic eo, input string nm);
        logic [31:0] oh;
        oh = 32'd1 << g;
        req_valid = vm;
        #1;
        chk({nm, "_req_ready"}, {30'b0, req_ready}, oh);
        chk({nm, "_idle_rsp_valid"}, {30'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        last_gnt = g;
        chk({nm, "_exec_rsp_valid"}, {30'b0, rsp_valid}, 32'd0);
        chk({nm, "_exec_req_ready"}, {30'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk({nm, "_rsp_valid"}, {30'b0, rsp_valid}, oh);
        chk({nm, "_rsp_data"}, rsp_data, ed);
        chk({nm, "_rsp_ovf"}, {31'b0, rsp_ovf}, {31'b0, eo});
        rsp_ready = oh[1:0];
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        #1;
        chk({nm, "_retired"}, {30'b0, rsp_valid}, 32'd0);
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        o;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{3'b000, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0};
        tbl[1] = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
        tbl[2] = '{3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
        tbl[3] = '{3'b011, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        tbl[4] = '{3'b010, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        tbl[5] = '{3'b100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
        tbl[6] = '{3'b111, 32'h00000001, 32'h00000004, 32'h00000010, 1'b0};
        tbl[7] = '{3'b110, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 1'b0};
        tbl[8] = '{3'b101, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0};

        resetn = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_func = '0;
        req_srca = '0;
        req_srcb = '0;
        #3;
        chk("rst_req_ready", {30'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_ovf", {31'b0, rsp_ovf}, 32'd0);
        chk("rst_alu_func", {29'b0, alu_func}, 32'd0);
        chk("rst_alu_srca", alu_srca, 32'd0);
        chk("rst_alu_srcb", alu_srcb, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        last_gnt = 1;

        // Contention straight out of reset: both requesters always valid.
        set_req(0, 3'b000, 32'd100, 32'd1);
        set_req(1, 3'b001, 32'd100, 32'd1);
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
            do_op(2'b11, k % 2, (k % 2 == 0) ? 32'd101 : 32'd99, 1'b0, "contend");
`else
            do_op(2'b11, 0, 32'd101, 1'b0, "contend");
`endif
        end

        for (int i = 0; i < 9; i++) begin
            set_req(i % 2, tbl[i].f, tbl[i].a, tbl[i].b);
            do_op((i % 2 == 0) ? 2'b01 : 2'b10, i % 2, tbl[i].d, tbl[i].o, "table");
        end

        // Backpressure on requester 1 with requester 0 arriving during RESP.
        set_req(1, 3'b000, 32'd10, 32'd20);
        set_req(0, 3'b001, 32'd50, 32'd8);
        req_valid = 2'b10;
        #1;
        chk("bp_grant", {30'b0, req_ready}, 32'd2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        last_gnt = 1;
        @(posedge clk); #1;
        rsp_ready = 2'b01;
        req_valid = 2'b01;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_rsp_valid", {30'b0, rsp_valid}, 32'd2);
            chk("bp_rsp_data", rsp_data, 32'd30);
            chk("bp_req_ready", {30'b0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 2'b10;
        #1;
        chk("bp_retire_req_ready", {30'b0, req_ready}, 32'd0);
        chk("bp_retire_rsp_valid", {30'b0, rsp_valid}, 32'd2);
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        do_op(2'b01, 0, 32'd42, 1'b0, "bp_waiter");

        // Asynchronous reset while in EXEC drops the operation.
        set_req(0, 3'b000, 32'h7FFFFFFF, 32'd1);
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        resetn = 1'b0;
        #1;
        chk("exec_rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
        chk("exec_rst_alu_srca", alu_srca, 32'd0);
        chk("exec_rst_rsp_data", rsp_data, 32'd0);
        chk("exec_rst_req_ready", {30'b0, req_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("exec_rst_hold_rsp_valid", {30'b0, rsp_valid}, 32'd0);
        end
        resetn = 1'b1;
        last_gnt = 1;
        @(posedge clk); #1;
        chk("post_rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
        set_req(0, 3'b000, 32'd5, 32'd3);
        do_op(2'b01, 0, 32'd8, 1'b0, "post_rst");

        // Randomised operations, sometimes contending.
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  vm;
            logic [2:0]  f;
            logic [31:0] a, b;
            int          g;
            for (int r = 0; r < 2; r++) begin
                f = 3'($urandom_range(0, 7));
                a = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
                b = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
                set_req(r, f, a, b);
            end
            vm = 2'($urandom_range(1, 3));
            g  = pick(vm);
            f  = req_func[3*g +: 3];
            a  = req_srca[32*g +: 32];
            b  = req_srcb[32*g +: 32];
            do_op(vm, g, alu_calc(f, a, b), exp_ovf(f, a, b), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
